// File: rtl/ext_fifo_pkg.sv
// Shared definitions for the RX external-FIFO store-and-forward controller.
package ext_fifo_pkg;

  localparam int DATA_W  = 8;
  localparam int ENTRY_W = DATA_W + 1;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_RECV    = 2'd1,
    WR_DISCARD = 2'd2
  } wr_state_e;

  // Buffer entry carries the end-of-frame marker above the data byte.
  function automatic logic [ENTRY_W-1:0] pack_entry(input logic eop, input logic [DATA_W-1:0] d);
    return {eop, d};
  endfunction

endpackage

// File: rtl/ext_fifo_rx_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
module ext_fifo_rx_ram
  import ext_fifo_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic               re_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  logic [ENTRY_W-1:0] mem_q [2**ADDR_W];

  // Read data holds when re_i is low; the controller relies on that as a skid slot.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/ext_fifo_rx_ctrl.sv
// Store-and-forward RX frame buffer: commit on clean EOP, roll back on error/overflow/flush.
module ext_fifo_rx_ctrl
  import ext_fifo_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_wr,
  input  logic              i_sop,
  input  logic              i_eop,
  input  logic              i_err,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_sop,
  output logic              o_eop,
  input  logic              i_ready,
  output logic              o_overflow,
  output logic [ADDR_W:0]   o_frames,
  output logic [CNT_W-1:0]  o_drop_cnt
);

  localparam logic [ADDR_W:0] DEPTH_P = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  wr_state_e          state_q, state_d;
  logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d, cm_ptr_q, cm_ptr_d, rd_ptr_q;
  logic [ADDR_W:0]    frames_q, frames_d;
  logic [CNT_W-1:0]   drop_q;
  logic [1:0]         drop_inc;
  logic               ovf_q, ovf_d, commit, start, full_start, full_cont;
  logic               ram_we, rd_en, out_free, eop_hs;
  logic [ADDR_W-1:0]  ram_waddr;
  logic [ENTRY_W-1:0] ram_rdata;
  logic               pend_q, valid_q, sop_q, eop_q, sop_nxt_q;
  logic [DATA_W-1:0]  data_q;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // A new frame always starts at the committed pointer, so an abort reuses the space at once.
  assign start      = i_wr && i_sop;
  assign full_start = (cm_ptr_q - rd_ptr_q) == DEPTH_P;
  assign full_cont  = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
  assign out_free   = !valid_q || i_ready;
  assign rd_en      = !i_flush && (rd_ptr_q != cm_ptr_q) && (!pend_q || out_free);
  assign eop_hs     = valid_q && i_ready && eop_q;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    cm_ptr_d  = cm_ptr_q;
    drop_inc  = 2'd0;
    commit    = 1'b0;
    ovf_d     = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = wr_ptr_q[ADDR_W-1:0];
    if (i_flush) begin
      state_d  = WR_IDLE;
      wr_ptr_d = '0;
      cm_ptr_d = '0;
      drop_inc = {1'b0, state_q == WR_RECV};
    end else if (start) begin
      if (state_q == WR_RECV) drop_inc = 2'd1;
      if (full_start || i_err) begin
        drop_inc = drop_inc + 2'd1;
        ovf_d    = full_start && !i_err;
        wr_ptr_d = cm_ptr_q;
        state_d  = i_eop ? WR_IDLE : WR_DISCARD;
      end else begin
        ram_we    = 1'b1;
        ram_waddr = cm_ptr_q[ADDR_W-1:0];
        wr_ptr_d  = cm_ptr_q + PTR_ONE;
        if (i_eop) begin
          cm_ptr_d = cm_ptr_q + PTR_ONE;
          commit   = 1'b1;
          state_d  = WR_IDLE;
        end else begin
          state_d = WR_RECV;
        end
      end
    end else begin
      case (state_q)
        WR_RECV: begin
          // Error outranks both overflow and EOP on the same beat.
          if (i_err) begin
            drop_inc = 2'd1;
            wr_ptr_d = cm_ptr_q;
            state_d  = (i_wr && i_eop) ? WR_IDLE : WR_DISCARD;
          end else if (i_wr) begin
            if (full_cont) begin
              drop_inc = 2'd1;
              ovf_d    = 1'b1;
              wr_ptr_d = cm_ptr_q;
              state_d  = i_eop ? WR_IDLE : WR_DISCARD;
            end else begin
              ram_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + PTR_ONE;
              if (i_eop) begin
                cm_ptr_d = wr_ptr_q + PTR_ONE;
                commit   = 1'b1;
                state_d  = WR_IDLE;
              end
            end
          end
        end
        WR_DISCARD: if (i_wr && i_eop) state_d = WR_IDLE;
        default: ;
      endcase
    end
    frames_d = i_flush ? '0
             : frames_q + {{ADDR_W{1'b0}}, commit} - {{ADDR_W{1'b0}}, eop_hs};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WR_IDLE;
      wr_ptr_q <= '0;
      cm_ptr_q <= '0;
      frames_q <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cm_ptr_q <= cm_ptr_d;
      frames_q <= frames_d;
      drop_q   <= sat_add(drop_q, drop_inc);
      ovf_q    <= ovf_d;
    end
  end

  ext_fifo_rx_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (pack_entry(i_eop, i_data)),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (ram_rdata)
  );

  // pend_q marks an unconsumed entry sitting in the RAM read register.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      rd_ptr_q  <= '0;
      pend_q    <= 1'b0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      data_q    <= '0;
      sop_nxt_q <= 1'b1;
    end else begin
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (rd_en) pend_q <= 1'b1;
      else if (out_free) pend_q <= 1'b0;
      if (out_free) begin
        valid_q <= pend_q;
        if (pend_q) begin
          data_q    <= ram_rdata[DATA_W-1:0];
          eop_q     <= ram_rdata[DATA_W];
          sop_q     <= sop_nxt_q;
          sop_nxt_q <= ram_rdata[DATA_W];
        end
      end
    end
  end

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_sop      = sop_q;
  assign o_eop      = eop_q;
  assign o_overflow = ovf_q;
  assign o_frames   = frames_q;
  assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_ext_fifo_rx_ctrl.sv
// Randomized bench for ext_fifo_rx_ctrl against a frame-level queue model.
module tb_ext_fifo_rx_ctrl;

  localparam int ADDR_W = 6;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int DMAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       i_data = '0;
  logic             i_wr = 1'b0, i_sop = 1'b0, i_eop = 1'b0, i_err = 1'b0;
  logic             i_flush = 1'b0, i_ready = 1'b0;
  logic [7:0]       o_data;
  logic             o_valid, o_sop, o_eop, o_overflow;
  logic [ADDR_W:0]  o_frames;
  logic [CNT_W-1:0] o_drop_cnt;

  ext_fifo_rx_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_data     (i_data),
    .i_wr       (i_wr),
    .i_sop      (i_sop),
    .i_eop      (i_eop),
    .i_err      (i_err),
    .i_flush    (i_flush),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_sop      (o_sop),
    .o_eop      (o_eop),
    .i_ready    (i_ready),
    .o_overflow (o_overflow),
    .o_frames   (o_frames),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] d;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] cur_q[$];
  bit         m_open, m_disc, m_ovf;
  int         m_frames, m_drop;
  int         n_chk, n_bad, n_beats;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic void m_dropped();
    if (m_drop < DMAX) m_drop++;
  endfunction

  function automatic void m_commit();
    for (int i = 0; i < cur_q.size(); i++)
      exp_q.push_back('{sop: (i == 0), eop: (i == cur_q.size() - 1), d: cur_q[i]});
    cur_q.delete();
    m_frames++;
    m_open = 0;
  endfunction

  // Occupancy is approximated by open bytes plus committed-but-unaccepted bytes;
  // exact whenever nothing committed is pending, which is how overflow is exercised.
  function automatic void m_edge(input bit wr, sop, eop, err, flush, input logic [7:0] d);
    m_ovf = 0;
    if (flush) begin
      if (m_open) m_dropped();
      m_open = 0; m_disc = 0;
      cur_q.delete(); exp_q.delete();
      m_frames = 0;
    end else if (wr && sop) begin
      if (m_open) begin m_dropped(); cur_q.delete(); m_open = 0; end
      if (exp_q.size() >= DEPTH || err) begin
        m_dropped(); m_ovf = !err; m_disc = !eop;
      end else begin
        m_disc = 0;
        cur_q.push_back(d);
        if (eop) m_commit(); else m_open = 1;
      end
    end else if (m_open) begin
      if (err) begin
        m_dropped(); cur_q.delete(); m_open = 0; m_disc = !(wr && eop);
      end else if (wr) begin
        if (cur_q.size() + exp_q.size() >= DEPTH) begin
          m_dropped(); m_ovf = 1; cur_q.delete(); m_open = 0; m_disc = !eop;
        end else begin
          cur_q.push_back(d);
          if (eop) m_commit();
        end
      end
    end else if (m_disc && wr && eop) begin
      m_disc = 0;
    end
  endfunction

  function automatic bit rdy(input int mode);
    return (mode == 2) ? ($urandom_range(3, 0) != 0) : (mode == 1);
  endfunction

  task automatic step(input bit wr, sop, eop, err, flush, input logic [7:0] d, input bit r);
    bit         stall;
    logic [9:0] held;
    beat_t      e;
    i_wr = wr; i_sop = sop; i_eop = eop; i_err = err; i_flush = flush; i_data = d; i_ready = r;
    stall = !flush && o_valid && !r;
    held  = {o_sop, o_eop, o_data};
    if (!flush && o_valid && r) begin
      n_beats++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat_data", o_data, e.d);
        check("beat_sop", o_sop, e.sop);
        check("beat_eop", o_eop, e.eop);
        if (e.eop) m_frames--;
      end
    end
    m_edge(wr, sop, eop, err, flush, d);
    @(posedge clk);
    @(negedge clk);
    check("frames", o_frames, m_frames);
    check("drop", o_drop_cnt, m_drop);
    check("overflow", o_overflow, m_ovf);
    if (stall) begin
      check("hold_valid", o_valid, 1);
      check("hold_beat", {o_sop, o_eop, o_data}, held);
    end
    if (exp_q.size() == 0) check("idle_valid", o_valid, 0);
  endtask

  task automatic idle(input int n, input int mode);
    repeat (n) step(0, 0, 0, 0, 0, 8'h00, rdy(mode));
  endtask

  task automatic send_frame(input int len, input int mode, input int err_at);
    for (int i = 0; i < len; i++)
      step(1, i == 0, i == len - 1, i == err_at, 0, 8'($urandom), rdy(mode));
  endtask

  task automatic drain(input int mode);
    int b = 0;
    while (exp_q.size() != 0 && b < 3000) begin
      step(0, 0, 0, 0, 0, 8'h00, rdy(mode));
      b++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    int len, g;
    bit s, er;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_sop", o_sop, 0);
    check("rst_eop", o_eop, 0);
    check("rst_data", o_data, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_frames", o_frames, 0);
    check("rst_drop", o_drop_cnt, 0);
    rst = 1'b0;

    // Full-depth frame streamed back at one byte per cycle.
    send_frame(64, 1, -1);
    check("t1_frames", o_frames, 1);
    n_beats = 0;
    idle(66, 1);
    check("t1_tput", n_beats, 64);

    // Errored frame is dropped; the following good frame survives.
    send_frame(15, 1, 9);
    send_frame(20, 1, -1);
    drain(1);
    check("t2_drop", o_drop_cnt, 1);

    // Single-byte frame appears two edges after the write.
    step(1, 1, 1, 0, 0, 8'hA5, 0);
    check("lat_n0", o_valid, 0);
    idle(1, 0);
    check("lat_n1", o_valid, 0);
    idle(1, 0);
    check("lat_valid", o_valid, 1);
    check("lat_data", o_data, 8'hA5);
    check("lat_sop", o_sop, 1);
    check("lat_eop", o_eop, 1);
    drain(1);

    // Oversized frame overflows on byte DEPTH+1; a full-depth frame then fits.
    send_frame(DEPTH + 4, 0, -1);
    idle(3, 0);
    check("t4_frames", o_frames, 0);
    check("t4_drop", o_drop_cnt, 2);
    check("t4_valid", o_valid, 0);
    send_frame(DEPTH, 0, -1);
    drain(1);

    // Two frames under random backpressure.
    send_frame($urandom_range(30, 1), 2, -1);
    send_frame($urandom_range(30, 1), 2, -1);
    drain(2);

    // Flush while streaming out with a frame half received.
    send_frame(20, 1, -1);
    send_frame(10, 1, -1);
    idle(5, 1);
    for (int i = 0; i < 3; i++) step(1, i == 0, 0, 0, 0, 8'($urandom), 1);
    step(0, 0, 0, 0, 1, 8'h00, 1);
    check("fl_valid", o_valid, 0);
    check("fl_frames", o_frames, 0);
    send_frame(8, 1, -1);
    drain(1);

    // Random traffic: errors, aborts, gaps, occasional flush.
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(29, 0) == 0) step(0, 0, 0, 0, 1, 8'h00, rdy(2));
      len = $urandom_range(40, 1);
      g = 0;
      while (exp_q.size() + len + 1 > DEPTH && g < 1000) begin
        step(0, 0, 0, 0, 0, 8'h00, 1);
        g++;
      end
      check("space_wait", (g < 1000), 1);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(4, 0) == 0)
          step(0, 0, 0, $urandom_range(49, 0) == 0, 0, 8'h00, rdy(2));
        s  = (i == 0) || ($urandom_range(39, 0) == 0);
        er = ($urandom_range(29, 0) == 0);
        step(1, s, i == len - 1, er, 0, 8'($urandom), rdy(2));
      end
    end
    drain(2);

    // Drop counter saturates.
    repeat (DMAX + 1) step(1, 1, 1, 1, 0, 8'($urandom), 1);
    check("drop_sat", o_drop_cnt, DMAX);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
